// File: rtl/logic_seq_pkg.sv
// Shared types and field layout for the logic vector sequencer.
package logic_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int VEC_W     = 5;
  localparam int ENTRY_W   = 6;
  localparam int EXP_Y_BIT = 5;
  localparam int A_BIT     = 4;
  localparam int B_BIT     = 3;
  localparam int C_BIT     = 2;
  localparam int D_BIT     = 1;
  localparam int E_BIT     = 0;

endpackage

// File: rtl/logic_seq_vec_store.sv
// Vector store: NUM_VEC x ENTRY_W registers, one sync write port,
// one async read port, synchronous clear on reset.
module logic_seq_vec_store
  import logic_seq_pkg::*;
#(
  parameter int NUM_VEC = 4,
  parameter int IDX_W   = $clog2(NUM_VEC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_wr_en,
  input  logic [IDX_W-1:0]   i_wr_addr,
  input  logic [ENTRY_W-1:0] i_wr_data,
  input  logic [IDX_W-1:0]   i_rd_addr,
  output logic [ENTRY_W-1:0] o_rd_data
);

  logic [ENTRY_W-1:0] r_mem [NUM_VEC];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_VEC; i++) r_mem[i] <= '0;
    end else if (i_wr_en && (int'(i_wr_addr) < NUM_VEC)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = (int'(i_rd_addr) < NUM_VEC) ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/logic_vector_sequencer.sv
// Steps a 5-bit stimulus vector through a programmable store, samples Y at the
// end of each dwell and counts mismatches. Optional macro: LOGIC_SEQ_MONITOR_GATE_EN.
module logic_vector_sequencer
  import logic_seq_pkg::*;
#(
  parameter int NUM_VEC = 4,
  parameter int DWELL   = 10,
  parameter int CNT_W   = 8,
  parameter int IDX_W   = $clog2(NUM_VEC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               vec_wr_en,
  input  logic [IDX_W-1:0]   vec_wr_addr,
  input  logic [ENTRY_W-1:0] vec_wr_data,
  output logic [VEC_W-1:0]   abcde,
  input  logic               y_in,
`ifdef LOGIC_SEQ_MONITOR_GATE_EN
  input  logic               monitor_en,
`endif
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   cur_idx,
  output logic               sample_valid,
  output logic               sample_y,
  output logic [CNT_W-1:0]   mismatch_cnt
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_VEC - 1);

  state_t             r_state, w_state_nxt;
  logic [DW_W-1:0]    r_dwell_cnt;
  logic [IDX_W-1:0]   r_cur_idx;
  logic [VEC_W-1:0]   r_abcde;
  logic               r_exp_y;
  logic               r_sample_valid;
  logic               r_sample_y;
  logic [CNT_W-1:0]   r_mismatch_cnt;

  logic               w_wr_en;
  logic [IDX_W-1:0]   w_rd_addr;
  logic [ENTRY_W-1:0] w_rd_data;
  logic [ENTRY_W-1:0] w_entry;
  logic               w_sample;
  logic               w_last;
  logic               w_cmp_en;
  logic               w_mismatch;

`ifdef LOGIC_SEQ_MONITOR_GATE_EN
  assign w_cmp_en = monitor_en;
`else
  assign w_cmp_en = 1'b1;
`endif

  assign w_wr_en = vec_wr_en && (r_state == IDLE);

  // Single read port: entry 0 while idle, the following entry while holding.
  // exp_y of the applied vector is latched alongside it in r_exp_y.
  assign w_rd_addr = (r_state == IDLE) ? '0 : r_cur_idx + 1'b1;

  logic_seq_vec_store #(
    .NUM_VEC (NUM_VEC),
    .IDX_W   (IDX_W)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (vec_wr_addr),
    .i_wr_data (vec_wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Forward a same-edge write so a start coinciding with it uses the new data.
  assign w_entry    = (w_wr_en && (vec_wr_addr == w_rd_addr)) ? vec_wr_data : w_rd_data;
  assign w_sample   = (r_state == HOLD) && (r_dwell_cnt == '0);
  assign w_last     = (r_cur_idx == IDX_LAST);
  assign w_mismatch = w_sample && w_cmp_en && (y_in != r_exp_y);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = HOLD;
      HOLD:    if (w_sample && w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == HOLD);
    done = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dwell_cnt    <= '0;
      r_cur_idx      <= '0;
      r_abcde        <= '0;
      r_exp_y        <= 1'b0;
      r_sample_valid <= 1'b0;
      r_sample_y     <= 1'b0;
      r_mismatch_cnt <= '0;
    end else begin
      r_sample_valid <= w_sample;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_abcde        <= w_entry[VEC_W-1:0];
            r_exp_y        <= w_entry[EXP_Y_BIT];
            r_cur_idx      <= '0;
            r_dwell_cnt    <= DWELL_LAST;
            r_mismatch_cnt <= '0;
          end
        end
        HOLD: begin
          if (!w_sample) begin
            r_dwell_cnt <= r_dwell_cnt - 1'b1;
          end else begin
            r_sample_y <= y_in;
            if (w_mismatch && (r_mismatch_cnt != '1))
              r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
            if (!w_last) begin
              r_cur_idx   <= r_cur_idx + 1'b1;
              r_abcde     <= w_entry[VEC_W-1:0];
              r_exp_y     <= w_entry[EXP_Y_BIT];
              r_dwell_cnt <= DWELL_LAST;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign abcde        = r_abcde;
  assign cur_idx      = r_cur_idx;
  assign sample_valid = r_sample_valid;
  assign sample_y     = r_sample_y;
  assign mismatch_cnt = r_mismatch_cnt;

endmodule

// File: doc/logic_vector_sequencer.md
Name: logic_vector_sequencer

Overview:
- Sequences the 5-input combinational test function: drives {A,B,C,D,E} from a small programmable vector store and holds each vector for a fixed dwell time.
- Samples Y at the end of each dwell, compares it against the stored expected value, and counts mismatches.
- Replaces hand-written stimulus timing with a reusable on-chip/bench-side scheduler sitting directly in front of the function under test.

Parameters:
- NUM_VEC, 4, number of vector entries (>=2).
- DWELL, 10, clock cycles each vector is held (>=1).
- CNT_W, 8, mismatch counter width.
- IDX_W, $clog2(NUM_VEC), index width (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous to clk, active-high.
- start  in  1  begin a run; honoured only in IDLE.
- vec_wr_en  in  1  write one vector entry; honoured only in IDLE.
- vec_wr_addr  in  IDX_W  entry index.
- vec_wr_data  in  6  {exp_y, A, B, C, D, E}; bit 5 is exp_y, bit 4 is A.
- abcde  out  5  stimulus to the function under test, {A,B,C,D,E}.
- y_in  in  1  Y returned from the function under test.
- busy  out  1  high in HOLD.
- done  out  1  one-cycle pulse at the end of a run.
- cur_idx  out  IDX_W  index of the vector currently applied.
- sample_valid  out  1  one-cycle pulse after each sample.
- sample_y  out  1  last sampled Y.
- mismatch_cnt  out  CNT_W  mismatches in the current/last run, saturating.

Behaviour:
- Reset (rst=1 at an edge):
  - Outputs: abcde=0, busy=0, done=0, cur_idx=0, sample_valid=0, sample_y=0, mismatch_cnt=0.
  - Vector store cleared to all-zero.
  - State goes to IDLE.
  - Reset mid-run aborts the run immediately; no done pulse.
- States: IDLE, HOLD, DONE.
- IDLE:
  - vec_wr_en writes the store at that edge.
  - If start is sampled high, then at that edge: abcde<=entry[0].abcde, cur_idx<=0, dwell_cnt<=DWELL-1, mismatch_cnt<=0, go to HOLD.
  - vec_wr_en and start in the same cycle: the write lands first; the run uses the new data.
- HOLD:
  - If dwell_cnt!=0: decrement it.
  - If dwell_cnt==0: capture sample_y<=y_in, assert sample_valid next cycle, and increment mismatch_cnt if y_in!=entry[cur_idx].exp_y.
  - Then, if cur_idx==NUM_VEC-1, go to DONE.
  - Otherwise, in the same edge: cur_idx++, abcde<=next entry, dwell_cnt<=DWELL-1.
  - Each vector is therefore held exactly DWELL cycles; y_in is sampled on the last cycle of the dwell.
- DONE: done=1 for exactly one cycle, then IDLE. abcde keeps the last vector until the next start.
- Latency: start edge to done-high cycle = NUM_VEC*DWELL cycles.
- start, vec_wr_en in HOLD/DONE: ignored; the store is not modified.
- mismatch_cnt: saturates at 2^CNT_W-1 and never wraps. Holds its value in IDLE; cleared only by reset or start.
- y_in is treated as combinational from abcde. The block adds no synchroniser.

Optional Feature:
- Macro: LOGIC_SEQ_MONITOR_GATE_EN.
- Defined: adds input monitor_en (1 bit).
  - Samples taken while monitor_en=0 still update sample_y and pulse sample_valid.
  - Those samples never increment mismatch_cnt.
  - This gives windowed checking, equivalent to monitor off/on.
- Not defined: no port; every sample is compared.

Decomposition:
- Package logic_seq_pkg:
  - state enum {IDLE, HOLD, DONE}.
  - VEC_W=5, ENTRY_W=6.
  - Field positions EXP_Y_BIT=5, A_BIT=4 .. E_BIT=0.
- Sub-module logic_seq_vec_store: NUM_VEC x ENTRY_W register file with one synchronous write port, one asynchronous read port, and synchronous reset to zero. The FSM and counters stay in the top.

Test Plan:
1. Reset then idle: hold rst 2 cycles, no start -> all outputs 0, state IDLE, abcde=00000.
2. Basic run, all match:
   - Load entries 00000, 10101, 11011, 11111; bench model returns exp_y correctly; pulse start.
   - Required response: abcde steps through the four vectors every 10 cycles, 4 sample_valid pulses, done 40 cycles after the start edge, mismatch_cnt=0.
3. Mismatch counting: same vectors with exp_y of entries 1 and 3 inverted -> mismatch_cnt=2 at done, and sample_y equals the model output each sample.
4. Ignored controls:
   - Assert start and vec_wr_en (addr 0, data 6'h3F) during HOLD.
   - Required response: the run is unaffected, entry 0 is unchanged on the next run, and there is exactly one done pulse.
5. Reset mid-run: rst at cycle 15 of a run -> next cycle abcde=0, busy=0, mismatch_cnt=0, and no done pulse. A following start runs cleanly from entry 0.
6. With LOGIC_SEQ_MONITOR_GATE_EN:
   - monitor_en=0 during vectors 0-1 and 1 during vectors 2-3; all four exp_y wrong.
   - Required response: mismatch_cnt=2.
   - Without the macro, the same stimulus gives mismatch_cnt=4.
